// File: rtl/ifq_pkg.sv
// Shared types and constants for the IF/ID instruction queue.
package ifq_pkg;

  localparam int IFQ_DEPTH  = 2;
  localparam int IFQ_WORD_W = 32;

  typedef struct packed {
    logic [IFQ_WORD_W-1:0] pc;
    logic [IFQ_WORD_W-1:0] instruction;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_mem.sv
// Entry storage for the IF/ID queue: register array, one write port and
// one asynchronous read port. Contents are not reset; the control logic
// in if_id_queue decides which entries are valid.
import ifq_pkg::*;

module ifq_mem #(
  parameter int DEPTH = IFQ_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  ifq_entry_t       wdata_i,
  input  logic [PTR_W-1:0] raddr_i,
  output ifq_entry_t       rdata_o
);

  ifq_entry_t mem_q [DEPTH];

  // Write the addressed entry on an accepted push.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_queue.sv
// IF/ID pipeline queue: first-word fall-through FIFO between fetch and
// decode with flush. in_ready depends on registered count only, so there
// is no combinational path from out_ready back to fetch.
// Optional feature: define IFQ_FLUSH_CNT_EN to add the 16-bit saturating
// flush_count output.
import ifq_pkg::*;

module if_id_queue #(
  parameter int DEPTH = IFQ_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [IFQ_WORD_W-1:0]     in_pc,
  input  logic [IFQ_WORD_W-1:0]     in_instruction,
  output logic                      in_ready,
  input  logic                      flush,
  output logic                      out_valid,
  output logic [IFQ_WORD_W-1:0]     out_pc,
  output logic [IFQ_WORD_W-1:0]     out_instruction,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH):0]    count
`ifdef IFQ_FLUSH_CNT_EN
  ,output logic [15:0]              flush_count
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  if (DEPTH < 2 || DEPTH > 8 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("if_id_queue: DEPTH must be a power of two in 2..8");
  end

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop, wr_en;
  ifq_entry_t       wr_entry, rd_entry;

  assign in_ready  = (count_q != CNT_FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign wr_en     = push && !flush;

  assign wr_entry.pc          = in_pc;
  assign wr_entry.instruction = in_instruction;

  ifq_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_entry)
  );

  // Empty queue shows zeros so decode never sees stale storage.
  assign out_pc          = out_valid ? rd_entry.pc          : '0;
  assign out_instruction = out_valid ? rd_entry.instruction : '0;
  assign count           = count_q;

  // Next pointers and count; flush overrides any same-cycle push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push && !pop)      count_d = count_q + CNT_ONE;
      else if (pop && !push) count_d = count_q - CNT_ONE;
    end
  end

  // Control state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

`ifdef IFQ_FLUSH_CNT_EN
  logic [15:0] flush_cnt_q;

  // Count flushes that actually discard something, saturating at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_cnt_q <= '0;
    end else if (flush && (out_valid || in_valid) && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue (DEPTH=2) with a queue-based model.
module tb_if_id_queue;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instruction;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instruction;
  logic        out_ready;
  logic [1:0]  count;
`ifdef IFQ_FLUSH_CNT_EN
  logic [15:0] flush_count;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        mq[$];
  int unsigned fc_m = 0;

  if_id_queue dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_pc           (in_pc),
    .in_instruction  (in_instruction),
    .in_ready        (in_ready),
    .flush           (flush),
    .out_valid       (out_valid),
    .out_pc          (out_pc),
    .out_instruction (out_instruction),
    .out_ready       (out_ready),
    .count           (count)
`ifdef IFQ_FLUSH_CNT_EN
    ,.flush_count    (flush_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_pc();
    return (mq.size() != 0) ? mq[0].pc : 32'h0;
  endfunction

  function automatic logic [31:0] m_ins();
    return (mq.size() != 0) ? mq[0].ins : 32'h0;
  endfunction

  // Drive one cycle of inputs, advance the model, land at posedge+1.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                      input logic rdy, input logic fl);
    int sz;
    ent_t e;
    in_valid = v; in_pc = pc; in_instruction = ins; out_ready = rdy; flush = fl;
    sz = mq.size();
    if (fl) begin
      if ((sz != 0 || v) && fc_m != 32'hFFFF) fc_m++;
      mq.delete();
    end else begin
      if (sz != 0 && rdy) void'(mq.pop_front());
      if (v && sz != DEPTH) begin
        e.pc = pc; e.ins = ins;
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_pc: got %0h expected 0", out_pc); end
    checks++; if (out_instruction !== 32'h0) begin errors++; $display("FAIL reset_out_instr: got %0h expected 0", out_instruction); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
`ifdef IFQ_FLUSH_CNT_EN
    checks++; if (flush_count !== 16'd0) begin errors++; $display("FAIL reset_flush_count: got %0d expected 0", flush_count); end
`endif
  endtask

  task automatic test_single_push();
    step(1'b1, 32'd4, 32'hE3A00014, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL push1_valid: got %0b expected 1", out_valid); end
    checks++; if (out_pc !== 32'd4) begin errors++; $display("FAIL push1_pc: got %0h expected 4", out_pc); end
    checks++; if (out_instruction !== 32'hE3A00014) begin errors++; $display("FAIL push1_instr: got %0h expected e3a00014", out_instruction); end
    checks++; if (count !== 2'd1) begin errors++; $display("FAIL push1_count: got %0d expected 1", count); end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL push1_drain: got count %0d valid %0b expected 0 0", count, out_valid); end
  endtask

  task automatic test_full();
    step(1'b1, 32'h100, 32'hAAAA0001, 1'b0, 1'b0);
    step(1'b1, 32'h104, 32'hAAAA0002, 1'b0, 1'b0);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %0b expected 0", in_ready); end
    checks++; if (count !== 2'd2) begin errors++; $display("FAIL full_count: got %0d expected 2", count); end
    step(1'b1, 32'h108, 32'hAAAA0003, 1'b0, 1'b0);
    checks++; if (count !== 2'd2 || out_pc !== 32'h100) begin errors++; $display("FAIL full_reject: got count %0d pc %0h expected 2 100", count, out_pc); end
    step(1'b1, 32'h108, 32'hAAAA0003, 1'b1, 1'b0);
    checks++; if (in_ready !== 1'b1 || count !== 2'd1) begin errors++; $display("FAIL full_pop_ready: got ready %0b count %0d expected 1 1", in_ready, count); end
    checks++; if (out_pc !== 32'h104 || out_instruction !== 32'hAAAA0002) begin errors++; $display("FAIL full_pop_head: got %0h/%0h expected 104/aaaa0002", out_pc, out_instruction); end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL full_drain: got %0d expected 0", count); end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 32'(4 * i), 32'hC0DE0000 + 32'(i), 1'b1, 1'b0);
      checks++;
      if (out_pc !== 32'(4 * i) || out_instruction !== 32'hC0DE0000 + 32'(i) || count !== 2'd1 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_%0d: got pc %0h instr %0h count %0d valid %0b expected pc %0h count 1", i, out_pc, out_instruction, count, out_valid, 4 * i);
      end
    end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL b2b_drain: got %0d expected 0", count); end
  endtask

  task automatic test_flush();
    step(1'b1, 32'h200, 32'h11111111, 1'b0, 1'b0);
    step(1'b1, 32'h204, 32'h22222222, 1'b0, 1'b0);
    step(1'b1, 32'h208, 32'h33333333, 1'b1, 1'b1);
    checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_count_valid: got %0d %0b expected 0 0", count, out_valid); end
    checks++; if (out_pc !== 32'h0 || out_instruction !== 32'h0) begin errors++; $display("FAIL flush_out_zero: got %0h/%0h expected 0/0", out_pc, out_instruction); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %0b expected 1", in_ready); end
`ifdef IFQ_FLUSH_CNT_EN
    checks++; if (flush_count !== 16'd1) begin errors++; $display("FAIL flush_cnt_one: got %0d expected 1", flush_count); end
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    checks++; if (flush_count !== 16'd1) begin errors++; $display("FAIL flush_cnt_idle: got %0d expected 1", flush_count); end
`endif
    step(1'b1, 32'h300, 32'h44444444, 1'b0, 1'b0);
    checks++; if (count !== 2'd1 || out_pc !== 32'h300) begin errors++; $display("FAIL flush_then_push: got count %0d pc %0h expected 1 300", count, out_pc); end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    step(1'b1, 32'h400, 32'h55555555, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || count !== 2'd0) begin errors++; $display("FAIL arst_immediate: got valid %0b count %0d expected 0 0", out_valid, count); end
    checks++; if (in_ready !== 1'b1 || out_pc !== 32'h0) begin errors++; $display("FAIL arst_outputs: got ready %0b pc %0h expected 1 0", in_ready, out_pc); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    mq.delete();
    fc_m = 0;
    step(1'b1, 32'h500, 32'h66666666, 1'b0, 1'b0);
    checks++; if (count !== 2'd1 || out_pc !== 32'h500) begin errors++; $display("FAIL arst_resume: got count %0d pc %0h expected 1 500", count, out_pc); end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_count1_pushpop();
    step(1'b1, 32'd8, 32'h88888888, 1'b0, 1'b0);
    step(1'b1, 32'd12, 32'hCCCCCCCC, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'd12 || count !== 2'd1) begin errors++; $display("FAIL c1_pushpop: got valid %0b pc %0h count %0d expected 1 c 1", out_valid, out_pc, count); end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 3) != 0), $urandom, $urandom, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0));
      checks++;
      if (count !== 2'(mq.size()) || out_valid !== (mq.size() != 0) || in_ready !== (mq.size() != DEPTH)) begin
        errors++;
        $display("FAIL rand_state_%0d: got count %0d valid %0b ready %0b expected count %0d", n, count, out_valid, in_ready, mq.size());
      end
      checks++;
      if (out_pc !== m_pc() || out_instruction !== m_ins()) begin
        errors++;
        $display("FAIL rand_head_%0d: got %0h/%0h expected %0h/%0h", n, out_pc, out_instruction, m_pc(), m_ins());
      end
`ifdef IFQ_FLUSH_CNT_EN
      checks++;
      if (flush_count !== 16'(fc_m)) begin
        errors++;
        $display("FAIL rand_flush_cnt_%0d: got %0d expected %0d", n, flush_count, fc_m);
      end
`endif
    end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_pc = '0; in_instruction = '0;
    out_ready = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b1;
    test_single_push();
    test_full();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_count1_pushpop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 2: number of entries; power of two, range 2..8.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1, fetch stage presents a PC/instruction pair.
REQ-005 SHALL have port in_pc, input, 32, PC+4 value from fetch.
REQ-006 SHALL have port in_instruction, input, 32, fetched instruction word.
REQ-007 SHALL have port in_ready, output, 1, queue can accept; fetch freeze = !in_ready.
REQ-008 SHALL have port flush, input, 1, branch taken in a later stage; discard all contents.
REQ-009 SHALL have port out_valid, output, 1, head entry valid for decode.
REQ-010 SHALL have port out_pc, output, 32, head entry PC.
REQ-011 SHALL have port out_instruction, output, 32, head entry instruction.
REQ-012 SHALL have port out_ready, input, 1, decode consumes the head this cycle (decode not frozen).
REQ-013 SHALL have port count, output, $clog2(DEPTH)+1, number of valid entries.

Function
REQ-014 SHALL accept a push when in_valid && in_ready, and pop when out_valid && out_ready.
REQ-015 SHALL drive in_ready = (count != DEPTH), from registered state only, with no combinational path from out_ready.
REQ-016 SHALL be first-word fall-through: a pushed entry appears on out_* one cycle after acceptance; zero added latency beyond that.
REQ-017 SHALL drive out_valid = (count != 0); out_pc/out_instruction SHALL be 0 when empty.
REQ-018 SHALL on simultaneous push and pop (non-empty, non-full) keep count unchanged and preserve FIFO order.
REQ-019 SHALL on push and pop in the same cycle at count==1 present the new entry on the next cycle with out_valid held high.
REQ-020 SHALL wrap read/write pointers modulo DEPTH without a gap or duplicated entry.
REQ-021 SHALL on flush set count to 0 and drop any same-cycle push and pop; flush has priority over both.
REQ-022 SHALL after flush accept a push on the very next cycle (in_ready high).
REQ-023 SHALL never overflow or underflow: push while full and pop while empty are impossible by REQ-014/015.

Reset
REQ-024 SHALL on rst low immediately clear pointers and count; out_valid=0, out_pc=0, out_instruction=0, in_ready=1.
REQ-025 SHALL discard all in-flight entries on reset mid-operation; storage contents need not be cleared.
REQ-026 SHALL resume normal operation on the first rising clk edge after rst deasserts.

Configuration
REQ-027 SHALL, when IFQ_FLUSH_CNT_EN is defined, add output flush_count (16 bits), reset to 0, incrementing by 1 on each flush cycle where count!=0 or in_valid was high, saturating at 0xFFFF.
REQ-028 SHALL, when IFQ_FLUSH_CNT_EN is undefined, omit the flush_count port and its logic entirely; all other behaviour identical.

Structure
REQ-029 SHALL place DEPTH default, the 32-bit word width constant, and the entry typedef {pc, instruction} in shared package ifq_pkg.
REQ-030 SHALL implement storage as sub-module ifq_mem (DEPTH-entry register array, one write port, one async read port); pointer and count control stay in if_id_queue.

Verification
REQ-031 SHALL cover: after reset, push (pc=4, instr=0xE3A00014) -> next cycle out_valid=1, out_pc=4, out_instruction=0xE3A00014, count=1.
REQ-032 SHALL cover: out_ready=0, push 2 entries with DEPTH=2 -> in_ready=0, count=2; third in_valid held is not accepted; out_ready=1 for 1 cycle -> in_ready=1.
REQ-033 SHALL cover: continuous push+pop for 10 cycles with pc=4,8,...,40 -> out_pc sequence 4..40 in order, count constant, pointers wrap.
REQ-034 SHALL cover: count=2 plus flush with in_valid=1 -> next cycle count=0, out_valid=0, out_* = 0, in_ready=1; flush_count=1 with IFQ_FLUSH_CNT_EN.
REQ-035 SHALL cover: rst driven low between clock edges with count=1 -> out_valid=0 immediately, before the next edge.
REQ-036 SHALL cover: count=1, push+pop same cycle (pc=8 popped, pc=12 pushed) -> out_valid stays 1, out_pc=12 next cycle.
